// File: rtl/dpr_load_pkg.sv
// Shared types for the command-memory load path: chunk counter, load word, core-id sizing.
// No logic here; widths cover the largest supported chunk and core-id configurations.
package dpr_load_pkg;

    localparam int CHUNK_CNT_W     = 8;
    localparam int LOAD_DATA_MAX_W = 64;
    localparam int CORE_ID_MAX_W   = 8;

    typedef logic [CHUNK_CNT_W-1:0] chunk_cnt_t;

    typedef struct packed {
        logic [LOAD_DATA_MAX_W-1:0] data;
        logic                       addr_set;
        logic [CORE_ID_MAX_W-1:0]   core;
    } load_word_t;

    function automatic int core_id_width(input int num_cores);
        return (num_cores > 1) ? $clog2(num_cores) : 1;
    endfunction

endpackage

// File: rtl/cmd_ptr_bank.sv
// Per-core auto-incrementing command write pointers with a wrap pulse.
// Latency: rd_ptr is combinational from state; set/inc take effect next cycle.
// Backpressure: none; set has priority over increment for the same core.
module cmd_ptr_bank #(
    parameter int NUM_CORES     = 2,
    parameter int ADDR_W        = 16,
    parameter int CORE_ID_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set_vld,
    input  logic [CORE_ID_WIDTH-1:0] set_core,
    input  logic [ADDR_W-1:0]        set_val,
    input  logic                     inc_vld,
    input  logic [CORE_ID_WIDTH-1:0] inc_core,
    input  logic [CORE_ID_WIDTH-1:0] rd_core,
    output logic [ADDR_W-1:0]        rd_ptr,
    output logic [NUM_CORES-1:0]     wrap_pls
);

    logic [ADDR_W-1:0] ptr_q [NUM_CORES];
    logic [ADDR_W-1:0] ptr_d [NUM_CORES];

    always_comb begin
        wrap_pls = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            ptr_d[i] = ptr_q[i];
            if (set_vld && (set_core == CORE_ID_WIDTH'(i))) begin
                ptr_d[i] = set_val;
            end else if (inc_vld && (inc_core == CORE_ID_WIDTH'(i))) begin
                // Natural overflow returns the pointer to 0; the pulse flags it.
                ptr_d[i]    = ptr_q[i] + ADDR_W'(1);
                wrap_pls[i] = &ptr_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
        end
    end

    assign rd_ptr = ptr_q[rd_core];

endmodule

// File: rtl/cmd_mem_loader.sv
// Assembles MEM_TO_CMD narrow chunks into one command and writes it to the owning core's cmd_mem bank.
// Latency: write strobe/addr/data registered, one cycle after the final chunk is accepted.
// Backpressure: load_ready drops for one cycle only after a core switch discards a partial command.
module cmd_mem_loader
    import dpr_load_pkg::*;
#(
    parameter int  NUM_CORES      = 2,
    parameter int  MEM_WIDTH      = 32,
    parameter int  MEM_TO_CMD     = 4,
    parameter int  CMD_ADDR_WIDTH = 16,
    parameter int  CORE_ID_WIDTH  = core_id_width(NUM_CORES),
    localparam int CMD_WIDTH      = MEM_WIDTH * MEM_TO_CMD
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [MEM_WIDTH-1:0]      load_data,
    input  logic                      load_addr_set,
    input  logic [CORE_ID_WIDTH-1:0]  load_core,
    input  logic                      err_clear,
    output logic [NUM_CORES-1:0]      mem_write_enable,
    output logic [CMD_ADDR_WIDTH-1:0] mem_write_addr,
    output logic [CMD_WIDTH-1:0]      mem_write_data,
    output logic                      err_partial,
    output logic [NUM_CORES-1:0]      err_wrap
);

    localparam chunk_cnt_t LAST_CHUNK = chunk_cnt_t'(MEM_TO_CMD - 1);

    load_word_t                word;
    logic                      unused_word;
    logic [MEM_WIDTH-1:0]      word_data;
    logic [CORE_ID_WIDTH-1:0]  word_core;

    chunk_cnt_t                cnt_q, cnt_d;
    chunk_cnt_t                chunk_slot;
    logic [CORE_ID_WIDTH-1:0]  owner_q, owner_d;
    logic [CMD_WIDTH-1:0]      asm_q, asm_d;
    logic                      stall_q, stall_d;
    logic [NUM_CORES-1:0]      we_q, we_d;
    logic [CMD_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CMD_WIDTH-1:0]      data_q, data_d;
    logic                      err_partial_q, err_partial_d;
    logic [NUM_CORES-1:0]      err_wrap_q, err_wrap_d;

    logic                      xfer;
    logic                      partial_set;
    logic                      commit;
    logic                      ptr_set_vld;
    logic [CORE_ID_WIDTH-1:0]  cmd_core;
    logic [CMD_ADDR_WIDTH-1:0] cmd_ptr;
    logic [NUM_CORES-1:0]      wrap_pls;

    assign word = '{
        data:     LOAD_DATA_MAX_W'(load_data),
        addr_set: load_addr_set,
        core:     CORE_ID_MAX_W'(load_core)
    };
    assign word_data   = word.data[MEM_WIDTH-1:0];
    assign word_core   = word.core[CORE_ID_WIDTH-1:0];
    assign unused_word = ^word;

    assign load_ready = ~stall_q;
    assign xfer       = load_valid && load_ready;

    always_comb begin
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        asm_d       = asm_q;
        stall_d     = 1'b0;
        we_d        = '0;
        addr_d      = addr_q;
        data_d      = data_q;
        partial_set = 1'b0;
        commit      = 1'b0;
        ptr_set_vld = 1'b0;
        cmd_core    = owner_q;
        chunk_slot  = cnt_q;

        if (xfer && word.addr_set) begin
            ptr_set_vld = 1'b1;
            if (cnt_q != '0) begin
                partial_set = 1'b1;
                cnt_d       = '0;
            end
        end else if (xfer) begin
            // A chunk from another core abandons the current command and restarts at chunk 0.
            if ((cnt_q != '0) && (word_core != owner_q)) begin
                partial_set = 1'b1;
                stall_d     = 1'b1;
                chunk_slot  = '0;
            end
            if (chunk_slot == '0) begin
                cmd_core = word_core;
            end
            owner_d = cmd_core;

            for (int k = 0; k < MEM_TO_CMD; k++) begin
                if (chunk_slot == chunk_cnt_t'(k)) begin
                    asm_d[k*MEM_WIDTH +: MEM_WIDTH] = word_data;
                end
            end

            if (chunk_slot == LAST_CHUNK) begin
                commit = 1'b1;
                cnt_d  = '0;
                we_d   = NUM_CORES'(1) << cmd_core;
                addr_d = cmd_ptr;
                data_d = asm_d;
            end else begin
                cnt_d = chunk_slot + chunk_cnt_t'(1);
            end
        end

        // A flag raised in the same cycle as err_clear survives the clear.
        err_partial_d = (err_partial_q & ~err_clear) | partial_set;
        err_wrap_d    = (err_wrap_q & {NUM_CORES{~err_clear}}) | wrap_pls;
    end

    cmd_ptr_bank #(
        .NUM_CORES     (NUM_CORES),
        .ADDR_W        (CMD_ADDR_WIDTH),
        .CORE_ID_WIDTH (CORE_ID_WIDTH)
    ) u_ptr_bank (
        .clk      (clk),
        .reset    (reset),
        .set_vld  (ptr_set_vld),
        .set_core (word_core),
        .set_val  (word.data[CMD_ADDR_WIDTH-1:0]),
        .inc_vld  (commit),
        .inc_core (cmd_core),
        .rd_core  (cmd_core),
        .rd_ptr   (cmd_ptr),
        .wrap_pls (wrap_pls)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            owner_q       <= '0;
            asm_q         <= '0;
            stall_q       <= 1'b0;
            we_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            err_partial_q <= 1'b0;
            err_wrap_q    <= '0;
        end else begin
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            asm_q         <= asm_d;
            stall_q       <= stall_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            err_partial_q <= err_partial_d;
            err_wrap_q    <= err_wrap_d;
        end
    end

    assign mem_write_enable = we_q;
    assign mem_write_addr   = addr_q;
    assign mem_write_data   = data_q;
    assign err_partial      = err_partial_q;
    assign err_wrap         = err_wrap_q;

endmodule

// File: tb/tb_cmd_mem_loader.sv
// Directed bench for cmd_mem_loader: queue-based reference model compared every cycle,
// plus literal expectations on captured writes and flags.
module tb_cmd_mem_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [31:0]  load_data = '0;
    logic         load_addr_set = 1'b0;
    logic [0:0]   load_core = '0;
    logic         err_clear = 1'b0;
    logic [1:0]   mem_write_enable;
    logic [15:0]  mem_write_addr;
    logic [127:0] mem_write_data;
    logic         err_partial;
    logic [1:0]   err_wrap;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cmd_mem_loader dut (
        .clk              (clk),
        .reset            (reset),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .load_data        (load_data),
        .load_addr_set    (load_addr_set),
        .load_core        (load_core),
        .err_clear        (err_clear),
        .mem_write_enable (mem_write_enable),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .err_partial      (err_partial),
        .err_wrap         (err_wrap)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: pointers as plain integers modulo 2^16, command as a chunk queue.
    int unsigned  m_ptr [2] = '{0, 0};
    logic [31:0]  m_chunks[$];
    logic [0:0]   m_owner = '0;
    logic [1:0]   exp_we = '0;
    logic [15:0]  exp_addr = '0;
    logic [127:0] exp_data = '0;
    logic         exp_perr = 1'b0;
    logic [1:0]   exp_wrap = '0;
    logic         exp_ready = 1'b1;

    always @(posedge clk or negedge reset) begin
        bit         perr_set;
        logic [1:0] wrap_set;
        bit         stall;
        if (!reset) begin
            m_ptr[0] = 0; m_ptr[1] = 0;
            m_chunks.delete();
            m_owner = '0;
            exp_we = '0; exp_addr = '0; exp_data = '0;
            exp_perr = 1'b0; exp_wrap = '0; exp_ready = 1'b1;
        end else begin
            perr_set = 0; wrap_set = '0; stall = 0;
            exp_we = '0;
            if (load_valid && exp_ready) begin
                if (load_addr_set) begin
                    m_ptr[load_core] = int'(load_data[15:0]);
                    if (m_chunks.size() != 0) begin
                        perr_set = 1;
                        m_chunks.delete();
                    end
                end else begin
                    if (m_chunks.size() != 0 && load_core != m_owner) begin
                        perr_set = 1;
                        stall = 1;
                        m_chunks.delete();
                    end
                    if (m_chunks.size() == 0) m_owner = load_core;
                    m_chunks.push_back(load_data);
                    if (m_chunks.size() == 4) begin
                        exp_we   = 2'b01 << m_owner;
                        exp_addr = 16'(m_ptr[m_owner]);
                        exp_data = {m_chunks[3], m_chunks[2], m_chunks[1], m_chunks[0]};
                        if (m_ptr[m_owner] == 65535) wrap_set[m_owner] = 1'b1;
                        m_ptr[m_owner] = (m_ptr[m_owner] + 1) % 65536;
                        m_chunks.delete();
                    end
                end
            end
            exp_perr  = (err_clear ? 1'b0 : exp_perr) | perr_set;
            exp_wrap  = (err_clear ? 2'b00 : exp_wrap) | wrap_set;
            exp_ready = !stall;
        end
    end

    typedef struct packed {
        logic [1:0]   en;
        logic [15:0]  addr;
        logic [127:0] data;
    } wr_t;
    wr_t wlog[$];

    always @(negedge clk) begin
        chk("we",      128'(mem_write_enable), 128'(exp_we));
        chk("addr",    128'(mem_write_addr),   128'(exp_addr));
        chk("data",    mem_write_data,         exp_data);
        chk("err_partial", 128'(err_partial),  128'(exp_perr));
        chk("err_wrap",    128'(err_wrap),     128'(exp_wrap));
        chk("ready",   128'(load_ready),       128'(exp_ready));
        if (reset && mem_write_enable != 2'b00)
            wlog.push_back('{en: mem_write_enable, addr: mem_write_addr, data: mem_write_data});
    end

    task automatic put(input bit v, input logic [31:0] d, input bit as, input logic [0:0] c,
                       input bit clr, output int tries);
        bit acc;
        load_valid = v; load_data = d; load_addr_set = as; load_core = c; err_clear = clr;
        tries = 0;
        do begin
            acc = load_ready;
            @(posedge clk); #1;
            tries++;
        end while (v && !acc && tries < 8);
        if (v && !acc) begin
            n_vec++; n_fail++;
            $display("FAIL put_accept: word %h not accepted within %0d cycles", d, tries);
        end
        load_valid = 1'b0; load_addr_set = 1'b0; err_clear = 1'b0;
    endtask

    task automatic chunk(input logic [0:0] c, input logic [31:0] d);
        int t;
        put(1'b1, d, 1'b0, c, 1'b0, t);
    endtask

    task automatic aset(input logic [0:0] c, input logic [15:0] a, input bit clr);
        int t;
        put(1'b1, {16'h0, a}, 1'b1, c, clr, t);
    endtask

    task automatic idle(input int n, input bit clr);
        int t;
        for (int i = 0; i < n; i++) put(1'b0, 32'h0, 1'b0, 1'b0, clr && (i == 0), t);
    endtask

    task automatic chk_wr(input string nm, input int idx, input logic [1:0] en,
                          input logic [15:0] a, input logic [127:0] d);
        wr_t w;
        w = (idx < wlog.size()) ? wlog[idx] : '0;
        chk({nm, "_en"},   128'(w.en),   128'(en));
        chk({nm, "_addr"}, 128'(w.addr), 128'(a));
        chk({nm, "_data"}, w.data,       d);
    endtask

    initial begin
        int t;
        int base;
        #2;
        chk("rst_we",    128'(mem_write_enable), 128'(0));
        chk("rst_ready", 128'(load_ready),       128'(1));
        chk("rst_wrap",  128'(err_wrap),         128'(0));
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle(2, 1'b0);

        // Basic command to core 0.
        chunk(0, 32'h11111111); chunk(0, 32'h22222222);
        chunk(0, 32'h33333333); chunk(0, 32'h44444444);
        chk("t1_strobe_now", 128'(mem_write_enable), 128'(2'b01));
        idle(2, 1'b0);
        chk("t1_count", 128'(wlog.size()), 128'(1));
        chk_wr("t1", 0, 2'b01, 16'h0000, 128'h44444444_33333333_22222222_11111111);

        // Address-set core 1, two commands; core 0 pointer untouched.
        aset(1, 16'h0010, 1'b0);
        for (int i = 0; i < 8; i++) chunk(1, 32'hA0000000 + i);
        for (int i = 0; i < 4; i++) chunk(0, 32'hB0000000 + i);
        idle(2, 1'b0);
        chk_wr("t2a", 1, 2'b10, 16'h0010, 128'hA0000003_A0000002_A0000001_A0000000);
        chk_wr("t2b", 2, 2'b10, 16'h0011, 128'hA0000007_A0000006_A0000005_A0000004);
        chk_wr("t2c", 3, 2'b01, 16'h0001, 128'hB0000003_B0000002_B0000001_B0000000);

        // Core switch mid-command.
        base = wlog.size();
        chunk(0, 32'hC0000000); chunk(0, 32'hC0000001);
        chunk(1, 32'hD0000000);
        chk("t3_err_partial", 128'(err_partial), 128'(1));
        chk("t3_ready_low",   128'(load_ready),  128'(0));
        put(1'b1, 32'hD0000001, 1'b0, 1'b1, 1'b0, t);
        chk("t3_stall_tries", 128'(t), 128'(2));
        chunk(1, 32'hD0000002); chunk(1, 32'hD0000003);
        idle(2, 1'b0);
        chk("t3_count", 128'(wlog.size() - base), 128'(1));
        chk_wr("t3", base, 2'b10, 16'h0012, 128'hD0000003_D0000002_D0000001_D0000000);
        idle(1, 1'b1);
        chk("t3_cleared", 128'(err_partial), 128'(0));

        // Pointer wrap on core 0.
        base = wlog.size();
        aset(0, 16'hFFFF, 1'b0);
        for (int i = 0; i < 4; i++) chunk(0, 32'hE0000000 + i);
        idle(1, 1'b0);
        chk("t4_wrap", 128'(err_wrap), 128'(2'b01));
        for (int i = 0; i < 4; i++) chunk(0, 32'hF0000000 + i);
        idle(2, 1'b0);
        chk_wr("t4a", base,     2'b01, 16'hFFFF, 128'hE0000003_E0000002_E0000001_E0000000);
        chk_wr("t4b", base + 1, 2'b01, 16'h0000, 128'hF0000003_F0000002_F0000001_F0000000);

        // Reset in the middle of a command.
        base = wlog.size();
        chunk(0, 32'h50000000); chunk(0, 32'h50000001); chunk(0, 32'h50000002);
        reset = 1'b0;
        #2;
        chk("t5_rst_we",   128'(mem_write_enable), 128'(0));
        chk("t5_rst_addr", 128'(mem_write_addr),   128'(0));
        chk("t5_rst_data", mem_write_data,         128'(0));
        chk("t5_rst_wrap", 128'(err_wrap),         128'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle(1, 1'b0);
        for (int i = 0; i < 4; i++) chunk(0, 32'h60000000 + i);
        idle(2, 1'b0);
        chk("t5_count", 128'(wlog.size() - base), 128'(1));
        chk_wr("t5", base, 2'b01, 16'h0000, 128'h60000003_60000002_60000001_60000000);

        // Clear colliding with a new discard, then a clear alone.
        base = wlog.size();
        chunk(0, 32'h70000000);
        aset(0, 16'h0020, 1'b1);
        chk("t6_set_wins", 128'(err_partial), 128'(1));
        idle(1, 1'b1);
        chk("t6_cleared", 128'(err_partial), 128'(0));
        for (int i = 0; i < 4; i++) chunk(0, 32'h80000000 + i);
        idle(2, 1'b0);
        chk_wr("t6", base, 2'b01, 16'h0020, 128'h80000003_80000002_80000001_80000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
